// File: rtl/load_store_unit.sv
// Load/store unit bridging the memory stage to a word-wide block RAM.
// Handles alignment checks, sub-word read-modify-write and load extension.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        ram_en,
  output logic        ram_we,
  output logic        ram_rst,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_di,
  input  logic [31:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    MERGE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] cap_addr;
  logic [1:0]  cap_size;
  logic        cap_uns;
  logic [15:0] cap_wdata;

  logic        req_err;
  logic        wr_word;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  logic [31:0] load_ext;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [31:0] merged;

  assign ram_rst   = 1'b0;
  assign req_ready = (state == IDLE) && rst;

  // Decode request legality and the single-cycle word store case
  always_comb begin
    req_err = 1'b0;
    unique case (1'b1)
      (req_size == 2'd3): req_err = 1'b1;
      (req_size == 2'd1): req_err = req_addr[0];
      (req_size == 2'd2): req_err = |req_addr[1:0];
      default:            req_err = 1'b0;
    endcase
    wr_word = req_we && (req_size == 2'd2);
  end

  // Pick the addressed lane out of the returned word and extend it
  always_comb begin
    sel_b = ram_dout[{cap_addr[1:0], 3'b000} +: 8];
    sel_h = cap_addr[1] ? ram_dout[31:16] : ram_dout[15:0];
    unique case (cap_size)
      2'd0:    load_ext = {{24{~cap_uns & sel_b[7]}}, sel_b};
      2'd1:    load_ext = {{16{~cap_uns & sel_h[15]}}, sel_h};
      default: load_ext = ram_dout;
    endcase
  end

  // Splice the store lane into the old word for the write-back
  always_comb begin
    if (cap_size == 2'd0) begin
      lane_mask = 32'h0000_00ff << {cap_addr[1:0], 3'b000};
      lane_data = {4{cap_wdata[7:0]}};
    end else begin
      lane_mask = cap_addr[1] ? 32'hffff_0000 : 32'h0000_ffff;
      lane_data = {2{cap_wdata}};
    end
    merged = (ram_dout & ~lane_mask) | (lane_data & lane_mask);
  end

  // Drive the RAM port; reset masks any access
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = {req_addr[31:2], 2'b00};
    ram_di   = req_wdata;
    unique case (state)
      IDLE: begin
        if (req_valid && !req_err) begin
          ram_en = 1'b1;
          ram_we = wr_word;
        end
      end
      MERGE: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = {cap_addr[31:2], 2'b00};
        ram_di   = merged;
      end
      default: begin
        ram_en = 1'b0;
      end
    endcase
    if (!rst) begin
      ram_en = 1'b0;
      ram_we = 1'b0;
    end
  end

  // Control FSM with registered response outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cap_addr   <= '0;
      cap_size   <= '0;
      cap_uns    <= 1'b0;
      cap_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_err) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (wr_word) begin
              resp_valid <= 1'b1;
            end else begin
              cap_addr  <= req_addr;
              cap_size  <= req_size;
              cap_uns   <= req_unsigned;
              cap_wdata <= req_wdata[15:0];
              state     <= req_we ? MERGE : LOAD;
            end
          end
        end
        LOAD: begin
          resp_valid <= 1'b1;
          resp_rdata <= load_ext;
          state      <= IDLE;
        end
        MERGE: begin
          resp_valid <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a RAM model and
// an in-order response scoreboard.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ram_en;
  logic        ram_we;
  logic        ram_rst;
  logic [31:0] ram_addr;
  logic [31:0] ram_di;
  logic [31:0] ram_dout;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem [0:255];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_rd = 0;
  int          n_wr = 0;
  int          n_en = 0;
  logic [31:0] last_wr = '0;

  load_store_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_rst      (ram_rst),
    .ram_addr     (ram_addr),
    .ram_di       (ram_di),
    .ram_dout     (ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM model, read-first, 1-cycle latency
  always @(posedge clk) begin
    if (ram_en === 1'b1) begin
      n_en++;
      if (ram_we === 1'b1) begin
        mem[ram_addr[9:2]] <= ram_di;
        n_wr++;
        last_wr <= ram_addr;
      end else begin
        n_rd++;
      end
      ram_dout <= mem[ram_addr[9:2]];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Pop and compare each response as it appears
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("resp_pending", 32'(q.size()), 32'd1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("resp_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic send(input logic        we,
                      input logic [1:0]  sz,
                      input logic        uns,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      input logic [31:0] er,
                      input logic        ee,
                      input int          lat,
                      input bit          push);
    int t;
    t = 0;
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    while (req_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready", {31'd0, req_ready}, 32'd1);
    if (push) begin
      exp_t e;
      e.rdata = er;
      e.err   = ee;
      e.due   = cyc + lat;
      q.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0;
    int wr0;
    int en0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    ram_dout     = '0;
    rst          = 1'b0;
    req_valid    = 1'b1;
    req_we       = 1'b0;
    req_size     = 2'd2;
    req_unsigned = 1'b0;
    req_addr     = 32'h100;
    req_wdata    = '0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
      chk("rst_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_resp", {31'd0, resp_valid}, 32'd0);
    end
    rst       = 1'b1;
    req_valid = 1'b0;
    #1 chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    send(1, 2, 0, 32'h100, 32'hdeadbeef, 0, 0, 1, 1);
    send(0, 2, 0, 32'h100, 0, 32'hdeadbeef, 0, 2, 1);
    drain();

    send(1, 2, 0, 32'h100, 32'h1280f0aa, 0, 0, 1, 1);
    send(0, 0, 0, 32'h101, 0, 32'hfffffff0, 0, 2, 1);
    send(0, 0, 1, 32'h101, 0, 32'h000000f0, 0, 2, 1);
    send(0, 1, 0, 32'h102, 0, 32'h00001280, 0, 2, 1);
    send(0, 0, 1, 32'h100, 0, 32'h000000aa, 0, 2, 1);
    send(0, 1, 0, 32'h100, 0, 32'hfffff0aa, 0, 2, 1);
    send(0, 1, 1, 32'h100, 0, 32'h0000f0aa, 0, 2, 1);
    send(0, 0, 0, 32'h103, 0, 32'h00000012, 0, 2, 1);
    drain();

    send(1, 2, 0, 32'h100, 32'h11223344, 0, 0, 1, 1);
    drain();
    rd0 = n_rd;
    wr0 = n_wr;
    send(1, 0, 0, 32'h103, 32'hffffff55, 0, 0, 2, 1);
    drain();
    chk("rmw_reads", 32'(n_rd - rd0), 32'd1);
    chk("rmw_writes", 32'(n_wr - wr0), 32'd1);
    chk("rmw_addr", last_wr, 32'h100);
    send(0, 2, 0, 32'h100, 0, 32'h55223344, 0, 2, 1);
    send(1, 1, 0, 32'h100, 32'h0000a5a5, 0, 0, 2, 1);
    send(0, 2, 0, 32'h100, 0, 32'h5522a5a5, 0, 2, 1);
    send(1, 0, 0, 32'h101, 32'h00000077, 0, 0, 2, 1);
    send(0, 0, 0, 32'h103, 0, 32'h00000055, 0, 2, 1);
    send(0, 2, 0, 32'h100, 0, 32'h552277a5, 0, 2, 1);
    drain();

    en0 = n_en;
    send(0, 1, 0, 32'h101, 0, 0, 1, 1, 1);
    send(1, 2, 0, 32'h102, 32'h12345678, 0, 1, 1, 1);
    send(0, 3, 0, 32'h000, 0, 0, 1, 1, 1);
    drain();
    chk("err_no_ram", 32'(n_en - en0), 32'd0);
    send(0, 2, 0, 32'h100, 0, 32'h552277a5, 0, 2, 1);
    drain();

    send(1, 2, 0, 32'h200, 32'hcafef00d, 0, 0, 1, 1);
    drain();
    wr0 = n_wr;
    send(1, 1, 0, 32'h200, 32'h0000beef, 0, 0, 2, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("abort_ram_we", {31'd0, ram_we}, 32'd0);
    @(negedge clk);
    chk("abort_resp", {31'd0, resp_valid}, 32'd0);
    chk("abort_ram_en", {31'd0, ram_en}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_resp2", {31'd0, resp_valid}, 32'd0);
    chk("abort_writes", 32'(n_wr - wr0), 32'd0);
    chk("abort_mem", mem[8'h80], 32'hcafef00d);
    send(0, 2, 0, 32'h200, 0, 32'hcafef00d, 0, 2, 1);
    drain();

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU memory stage and the word-wide, single-port block RAM. The RAM has a 1-cycle read latency, a byte address with word index addr[31:2], and a full-word write enable only.
- Accepts byte/half/word loads and stores, and checks alignment.
- Performs read-modify-write for sub-word stores.
- Lane-selects and sign/zero-extends load data.
- Returns one response per accepted request.

Parameters:
- None. Data and address widths are fixed at 32.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-low reset (0 = reset), sampled on posedge clk.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; a transfer occurs when req_valid && req_ready at posedge.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 illegal.
- req_unsigned  in  1  load zero-extend (1) or sign-extend (0); ignored for stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle response pulse; no backpressure.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal size; qualified by resp_valid.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_rst  out  1  RAM output reset; constant 0.
- ram_addr  out  32  RAM byte address, always word-aligned ({addr[31:2],2'b00}).
- ram_di  out  32  RAM write data.
- ram_dout  in  32  RAM read data, valid the cycle after the read enable.

Behaviour:
- States: IDLE, LOAD, MERGE.
- req_ready = (state==IDLE) && rst.
- Reset (rst=0 at posedge): state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, captured registers cleared.
  - While rst=0, ram_en=0 and ram_we=0 are forced combinationally.
  - A MERGE write in flight is abandoned; memory is unchanged.
- Alignment error: size==3, or size==1 && addr[0], or size==2 && addr[1:0]!=0.
  - No RAM access (ram_en=0).
  - Next cycle: resp_valid=1, resp_err=1, resp_rdata=0. State stays IDLE.
- In IDLE, RAM outputs are driven combinationally from req_* while req_valid && !error. Otherwise ram_en=0.
- Load:
  - Accept edge E0: ram_en=1, ram_we=0. Capture addr[1:0], size, unsigned. Go to LOAD.
  - LOAD cycle: select from ram_dout.
    - Byte lane = addr[1:0], little-endian: lane0 = [7:0].
    - Half lane = addr[1]: 0 = [15:0], 1 = [31:16].
    - Extend per unsigned.
  - Edge E1: register resp_rdata, resp_valid=1, resp_err=0. Go to IDLE.
  - Latency: response is visible 2 cycles after the accept edge.
- Word store:
  - At E0: ram_en=1, ram_we=1, ram_di=req_wdata.
  - Next cycle: resp_valid=1, rdata=0. State stays IDLE.
- Sub-word store:
  - At E0: issue read (ram_en=1, ram_we=0). Capture addr, size, wdata. Go to MERGE.
  - MERGE cycle: ram_en=1, ram_we=1, ram_addr=captured, ram_di=ram_dout with the target lane replaced by wdata[7:0] or wdata[15:0].
  - At E1: write occurs, resp_valid=1. Go to IDLE.
- A new request may be accepted in the same cycle resp_valid is high.
  - Throughput: 1 word store or error per cycle; 1 load or sub-word store per 2 cycles.
- resp_valid is high exactly one cycle per accepted request. Responses are in order.
- Back-to-back sub-word store followed by a load to the same word: the load is issued after the write edge, so it returns the merged data.
- req_* are don't-care when not accepted. A request with req_valid=1 outside IDLE is held by the requester.

Test Plan:
1. Reset held 3 cycles with req_valid=1 -> ram_en=0, req_ready=0, resp_valid=0 throughout. After release, req_ready=1.
2. Word store 0xDEADBEEF @0x100, then word load @0x100 -> store response 1 cycle after accept. Load response 0xDEADBEEF exactly 2 cycles after accept, resp_err=0.
3. Byte loads @0x101 after storing 0x1280F0AA @0x100: signed -> 0xFFFFFFF0; unsigned -> 0x000000F0. Half load @0x102 signed -> 0x00001280.
4. Byte store 0x55 @0x103 over 0x11223344 -> exactly one read then one write to word 0x100. Word becomes 0x55223344; response 2 cycles after accept.
5. Half load @0x101 and word store @0x102 -> resp_err=1, rdata=0, no ram_en pulse, response next cycle. req_size=3 @0x0 -> same.
6. rst=0 asserted during MERGE of a half store 0xBEEF @0x200 (old 0xCAFEF00D) -> no write issued, word remains 0xCAFEF00D, resp_valid stays 0.
